// File: rtl/sent_rx_frame_decoder.sv
// SENT receive frame decoder.
// Measures the time between falling edges of the SENT line in ticks and decodes
// sync, status, six data nibbles and a CRC nibble. A frame that passes the CRC
// is published on status_o/data_o. Any error is reported as a one-cycle pulse.
module sent_rx_frame_decoder (
  input  logic        clk_rx,
  input  logic        reset_rx,
  input  logic        sent_rx_i,
  input  logic        enable_i,
  input  logic        pause_en_i,
  input  logic [7:0]  divide_i,
  output logic [3:0]  status_o,
  output logic [23:0] data_o,
  output logic        frame_valid_o,
  output logic        crc_err_o,
  output logic        pulse_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_STATUS,
    ST_DATA,
    ST_CRC,
    ST_END
  } state_t;

  // 4-bit CRC lookup table used by the SENT CRC.
  function automatic logic [3:0] crc_tbl(input logic [3:0] idx);
    logic [3:0] r;
    case (idx)
      4'h0:    r = 4'h0;
      4'h1:    r = 4'hd;
      4'h2:    r = 4'h7;
      4'h3:    r = 4'ha;
      4'h4:    r = 4'he;
      4'h5:    r = 4'h3;
      4'h6:    r = 4'h9;
      4'h7:    r = 4'h4;
      4'h8:    r = 4'h1;
      4'h9:    r = 4'hc;
      4'ha:    r = 4'h6;
      4'hb:    r = 4'hb;
      4'hc:    r = 4'hf;
      4'hd:    r = 4'h2;
      4'he:    r = 4'h8;
      default: r = 4'h5;
    endcase
    return r;
  endfunction

  logic        sync1_reg;
  logic        sync2_reg;
  logic        dly_reg;
  logic        fall_det;
  logic [7:0]  div_eff;
  logic [7:0]  prescale_reg;
  logic [9:0]  tick_reg;
  logic        round_up;
  logic [10:0] t_meas;
  logic        t_is_sync;
  logic        t_is_nibble;
  logic        t_is_pause;
  logic [3:0]  nib_val;

  state_t      state_reg;
  logic [2:0]  idx_reg;
  logic [3:0]  crc_reg;
  logic [3:0]  status_buf_reg;
  logic [23:0] data_buf_reg;

  // Synchronize the asynchronous line; the extra delay stage gives edge detect.
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      dly_reg   <= 1'b1;
    end else begin
      sync1_reg <= sent_rx_i;
      sync2_reg <= sync1_reg;
      dly_reg   <= sync2_reg;
    end
  end

  assign fall_det = dly_reg & ~sync2_reg;

  // A divide of zero behaves as one clock per tick.
  assign div_eff = (divide_i == 8'd0) ? 8'd1 : divide_i;

  // Prescaler and saturating tick counter, restarted at every falling edge.
  always_ff @(posedge clk_rx) begin
    if (reset_rx || !enable_i || fall_det) begin
      prescale_reg <= 8'd0;
      tick_reg     <= 10'd0;
    end else if (prescale_reg >= div_eff - 8'd1) begin
      prescale_reg <= 8'd0;
      if (tick_reg != 10'd1023) begin
        tick_reg <= tick_reg + 10'd1;
      end
    end else begin
      prescale_reg <= prescale_reg + 8'd1;
    end
  end

  // Round the interval to the nearest tick using the partial prescale count.
  assign round_up    = (prescale_reg >= (div_eff >> 1));
  assign t_meas      = {1'b0, tick_reg} + {10'd0, round_up};
  assign t_is_sync   = (t_meas >= 11'd55) && (t_meas <= 11'd57);
  assign t_is_nibble = (t_meas >= 11'd12) && (t_meas <= 11'd27);
  assign t_is_pause  = (t_meas >= 11'd12) && (t_meas <= 11'd768);
  assign nib_val     = t_meas[3:0] - 4'd12;

  // Frame FSM; advances only on falling edges and owns all registered outputs.
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= 3'd0;
      crc_reg        <= 4'h5;
      status_buf_reg <= 4'h0;
      data_buf_reg   <= 24'h0;
      status_o       <= 4'h0;
      data_o         <= 24'h0;
      frame_valid_o  <= 1'b0;
      crc_err_o      <= 1'b0;
      pulse_err_o    <= 1'b0;
    end else begin
      frame_valid_o <= 1'b0;
      crc_err_o     <= 1'b0;
      pulse_err_o   <= 1'b0;
      if (!enable_i) begin
        state_reg <= ST_IDLE;
      end else if (fall_det) begin
        case (state_reg)
          ST_IDLE: begin
            state_reg <= ST_SYNC;
          end
          ST_SYNC: begin
            if (t_is_sync) begin
              state_reg <= ST_STATUS;
            end
          end
          ST_STATUS: begin
            if (t_is_nibble) begin
              status_buf_reg <= nib_val;
              crc_reg        <= 4'h5;
              idx_reg        <= 3'd0;
              state_reg      <= ST_DATA;
            end else begin
              pulse_err_o <= 1'b1;
              state_reg   <= ST_SYNC;
            end
          end
          ST_DATA: begin
            if (t_is_nibble) begin
              data_buf_reg <= {data_buf_reg[19:0], nib_val};
              crc_reg      <= nib_val ^ crc_tbl(crc_reg);
              if (idx_reg == 3'd5) begin
                state_reg <= ST_CRC;
              end else begin
                idx_reg <= idx_reg + 3'd1;
              end
            end else begin
              pulse_err_o <= 1'b1;
              state_reg   <= ST_SYNC;
            end
          end
          ST_CRC: begin
            if (t_is_nibble) begin
              if (nib_val == crc_tbl(crc_reg)) begin
                frame_valid_o <= 1'b1;
                status_o      <= status_buf_reg;
                data_o        <= data_buf_reg;
              end else begin
                crc_err_o <= 1'b1;
              end
              state_reg <= ST_END;
            end else begin
              pulse_err_o <= 1'b1;
              state_reg   <= ST_SYNC;
            end
          end
          ST_END: begin
            if (t_is_sync) begin
              state_reg <= ST_STATUS;
            end else if (pause_en_i && t_is_pause) begin
              state_reg <= ST_SYNC;
            end else begin
              pulse_err_o <= 1'b1;
              state_reg   <= ST_SYNC;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/sent_rx_frame_decoder.md
SENT_RX_FRAME_DECODER -- requirements
Module: sent_rx_frame_decoder

Interface
REQ-001 SHALL have one clock and one reset. Reset is synchronous and active-high: clk_rx, reset_rx.
REQ-002 SHALL have port clk_rx, input, 1 bit: receive clock, all logic on rising edge.
REQ-003 SHALL have port reset_rx, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port sent_rx_i, input, 1 bit: asynchronous SENT line.
REQ-005 SHALL have port enable_i, input, 1 bit: decoder enable.
REQ-006 SHALL have port pause_en_i, input, 1 bit: pause pulse permitted after CRC.
REQ-007 SHALL have port divide_i, input, 8 bits: clk_rx cycles per tick; 0 is treated as 1.
REQ-008 SHALL have port status_o, output, 4 bits: last valid status nibble.
REQ-009 SHALL have port data_o, output, 24 bits: last valid 6 data nibbles, first received in [23:20].
REQ-010 SHALL have port frame_valid_o, output, 1 bit: one-cycle pulse when a frame passes CRC.
REQ-011 SHALL have port crc_err_o, output, 1 bit: one-cycle pulse when the CRC mismatches.
REQ-012 SHALL have port pulse_err_o, output, 1 bit: one-cycle pulse on an illegal interval.

Function
REQ-013 SHALL pass sent_rx_i through a 2-FF synchronizer plus a delay FF; fall_det = delayed & ~synced.
REQ-014 SHALL measure each falling-to-falling interval as follows:
- A prescale counter counts 0..divide_i-1.
- The 10-bit tick counter increments on prescale wrap and saturates at 1023.
- Measured T = tick_cnt + (prescale >= divide_i>>1).
- Both counters clear on fall_det.
REQ-015 SHALL implement FSM states IDLE, SYNC, STATUS, DATA, CRC, END.
REQ-016 SHALL leave IDLE for SYNC on the first fall_det while enable_i=1; that interval is discarded.
REQ-017 SHALL, in SYNC, on fall_det with T in 55..57, go to STATUS; otherwise stay in SYNC with no error pulse.
REQ-018 SHALL decode a nibble interval T in 12..27 as value T-12.
REQ-019 SHALL, for a nibble interval outside 12..27 in STATUS/DATA/CRC, pulse pulse_err_o and go to SYNC.
REQ-020 SHALL, in STATUS, store the status nibble and go to DATA with index 0.
REQ-021 SHALL, in DATA, store the nibble at the index; index 5 goes to CRC.
REQ-022 SHALL, in CRC, compare the received nibble with the computed CRC, then go to END:
- On match: pulse frame_valid_o and update status_o/data_o in the same cycle.
- On mismatch: pulse crc_err_o and leave outputs unchanged.
REQ-023 SHALL compute the CRC over the 6 data nibbles only (status excluded):
- Seed 4'h5.
- For each nibble: c = nibble ^ TBL[c].
- Final step: c = TBL[c].
- TBL = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}.
REQ-024 SHALL, in END, handle the next fall_det as follows:
- T in 55..57: go to STATUS (back-to-back frame).
- Else if pause_en_i=1 and T in 12..768: go to SYNC.
- Else: pulse pulse_err_o and go to SYNC.
REQ-025 SHALL assert frame_valid_o, crc_err_o and pulse_err_o with 2-cycle latency: the input is first sampled low at clock edge k, and the pulse is high in the cycle after edge k+2.
REQ-026 SHALL, when enable_i=0, force IDLE, clear both counters and suppress all pulses; outputs hold their values.
REQ-027 SHALL use a saturated tick count (1023) in every comparison above.

Reset
REQ-028 SHALL, on reset_rx=1 at a clock edge, produce: FSM=IDLE, counters=0, synchronizer FFs=1, status_o=0, data_o=0, all pulses=0.
REQ-029 SHALL, on reset mid-frame, discard the partial frame; the next frame requires a fresh IDLE/SYNC hunt.

Verification (divide_i=4 unless noted)
REQ-030 SHALL be checked with: enable_i=1, sync(56), status 3, data 0,0,0,0,0,0, CRC 5, then sync -> frame_valid_o one pulse, status_o=4'h3, data_o=24'h000000.
REQ-031 SHALL be checked with: data 1,2,3,4,5,6, CRC 2 -> data_o=24'h123456; same frame with CRC 3 -> crc_err_o pulse, data_o unchanged.
REQ-032 SHALL be checked with: a data nibble interval of 30 ticks -> pulse_err_o pulse; the next valid frame decodes normally.
REQ-033 SHALL be checked with: pause_en_i=1, a 200-tick pause after CRC, then a frame -> decodes; pause_en_i=0 with the same stimulus -> pulse_err_o, and the following frame still decodes after the SYNC hunt.
REQ-034 SHALL be checked with: divide_i=0 and sync of 56 clk_rx cycles -> accepted as sync; a 54-tick or 58-tick "sync" -> rejected, no pulse.
REQ-035 SHALL be checked with: reset_rx after data nibble 3 -> outputs 0, no pulse; frame_valid_o fires only on a later complete frame.
